fft_bfly_sched: RTL and testbench
=================================

FFT_BFLY_SCHED -- requirements
Module: fft_bfly_sched

Interface
REQ-001 Parameter LOG2N, default 4, log2 of the transform length N; legal range 2..10.
REQ-002 Parameter PIPE_LAT, default 3, cycles from read issue to write-back (memory read plus butterfly register stage); legal range 1..8.
REQ-003 Ports: clock is clk; reset is rst_n. The block has one clock, and reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; every state element is rising-edge triggered.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to run a full in-place radix-2 DIT transform.
REQ-007 busy  output  1  high while a transform is in progress.
REQ-008 done  output  1  one-cycle pulse when the final write-back has completed.
REQ-009 rd_en  output  1  operand read strobe; one butterfly issued per asserted cycle.
REQ-010 rd_addr_a, rd_addr_b  output  LOG2N each  top and bottom operand addresses.
REQ-011 tw_addr  output  LOG2N-1  twiddle ROM index (wr, wi) for the issued butterfly.
REQ-012 wr_en  output  1  result write strobe; fires PIPE_LAT cycles after the matching rd_en.
REQ-013 wr_addr_a, wr_addr_b  output  LOG2N each  destination addresses for z1 and z2; equal to the delayed rd_addr_a and rd_addr_b.
REQ-014 stage  output  log2(LOG2N)+1  current stage index, for debug and twiddle-bank selection.

Function
REQ-015 The FSM has four states: IDLE, RUN, DRAIN and FIN.
REQ-016 IDLE: a start sampled high moves the FSM to RUN with stage=0 and k=0.
REQ-017 RUN: rd_en=1 every cycle; k increments by 1 each cycle; after k=N/2-1 the FSM moves to DRAIN.
REQ-018 Addressing for stage s and butterfly k uses span=2^s, grp=k>>s, pos=k&(span-1):
- rd_addr_a = grp*2*span + pos
- rd_addr_b = rd_addr_a + span
- tw_addr = pos << (LOG2N-1-s)
REQ-019 DRAIN: rd_en=0 for exactly PIPE_LAT cycles so that every write of stage s lands before any read of stage s+1 (no read-after-write hazard).
REQ-020 At the end of DRAIN, if s<LOG2N-1 the FSM increments s, clears k and returns to RUN; otherwise it goes to FIN.
REQ-021 FIN lasts one cycle: done=1 and busy=0; the FSM then returns to IDLE.
REQ-022 busy=1 in the RUN and DRAIN states only.
REQ-023 Write-back uses a PIPE_LAT-deep shift register of {valid, addr_a, addr_b}; wr_en is the valid bit at the tail.
REQ-024 start is ignored while busy=1 or in FIN; there is no queuing.
REQ-025 A start coincident with FIN is dropped; a start on the cycle after FIN is accepted.
REQ-026 All arithmetic is unsigned modulo 2^LOG2N; rd_addr_b never wraps for legal s.
REQ-027 Latency: start in cycle 0 gives the first rd_en in cycle 1; done occurs in cycle 1 + LOG2N*(N/2 + PIPE_LAT).

Reset
REQ-028 rst_n low at any time forces the FSM to IDLE and clears the stage and k counters and the write-back pipe.
REQ-029 During reset busy, done, rd_en and wr_en are 0, and all address outputs are 0.
REQ-030 A reset during operation drops in-flight writes: no wr_en is asserted after rst_n deasserts until a new start is accepted.
REQ-031 Reset deassertion is synchronized externally; the block itself takes no action on the deasserting edge.

Structure
REQ-032 A shared package holds the FSM state enum and the address-math helpers (span, twiddle shift).
REQ-033 A single sub-module fft_wb_pipe implements the parameterized valid+address delay line.
REQ-034 The butterfly datapath, operand memory and twiddle ROM are outside this block.

Verification
REQ-035 LOG2N=3, PIPE_LAT=3, start in cycle 0 -> rd_en in cycles 1-4, 8-11 and 15-18; done only in cycle 22; busy high in cycles 1-21.
REQ-036 Stage 0, k=0 -> (a,b,tw)=(0,1,0); stage 1, k=1 -> (1,3,2); stage 2, k=3 -> (3,7,3).
REQ-037 Every rd_en in cycle t is matched by wr_en in cycle t+3 with identical addresses; a total of 12 writes occurs.
REQ-038 start repeated in cycles 5 and 22 -> both are ignored, with a single done; start in cycle 23 -> a new run begins with the first rd_en in cycle 24.
REQ-039 rst_n pulled low in cycle 9 -> all outputs are 0 immediately; no wr_en appears after release; the next start behaves as in REQ-035.
REQ-040 A scoreboard model of an 8-point FFT using the butterfly equations matches a reference DFT within 2 LSB for impulse and DC inputs.

Source files
------------

// File: rtl/fft_bfly_sched_pkg.sv
// Shared FSM state encoding and radix-2 DIT address helpers for the butterfly scheduler.
package fft_bfly_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

  function automatic int unsigned bfly_span(input int unsigned s);
    return 32'd1 << s;
  endfunction

  // Top operand: groups are 2*span apart, pos selects the element within a group.
  function automatic int unsigned bfly_addr_a(input int unsigned k, input int unsigned s);
    return ((k >> s) << (s + 32'd1)) + (k & (bfly_span(s) - 32'd1));
  endfunction

  function automatic int unsigned bfly_tw(input int unsigned k, input int unsigned s,
                                          input int unsigned log2n);
    return (k & (bfly_span(s) - 32'd1)) << (log2n - 32'd1 - s);
  endfunction

endpackage

// File: rtl/fft_wb_pipe.sv
// Delay line carrying {valid, addr_a, addr_b} from operand read to result write-back.
module fft_wb_pipe
  import fft_bfly_sched_pkg::*;
#(
  parameter int PIPE_LAT = 3,
  parameter int AW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic          vld_o,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o
);

  logic          vld_q    [PIPE_LAT];
  logic [AW-1:0] addr_a_q [PIPE_LAT];
  logic [AW-1:0] addr_b_q [PIPE_LAT];

  // Addresses are cleared too so every write-side output reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        vld_q[i]    <= 1'b0;
        addr_a_q[i] <= '0;
        addr_b_q[i] <= '0;
      end
    end else begin
      vld_q[0]    <= vld_i;
      addr_a_q[0] <= addr_a_i;
      addr_b_q[0] <= addr_b_i;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_q[i]    <= vld_q[i-1];
        addr_a_q[i] <= addr_a_q[i-1];
        addr_b_q[i] <= addr_b_q[i-1];
      end
    end
  end

  assign vld_o    = vld_q[PIPE_LAT-1];
  assign addr_a_o = addr_a_q[PIPE_LAT-1];
  assign addr_b_o = addr_b_q[PIPE_LAT-1];

endmodule

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT butterfly scheduler: issues operand reads stage by stage,
// drains the datapath between stages and replays the addresses for write-back.
module fft_bfly_sched
  import fft_bfly_sched_pkg::*;
#(
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [LOG2N-1:0]           rd_addr_a,
  output logic [LOG2N-1:0]           rd_addr_b,
  output logic [LOG2N-2:0]           tw_addr,
  output logic                       wr_en,
  output logic [LOG2N-1:0]           wr_addr_a,
  output logic [LOG2N-1:0]           wr_addr_b,
  output logic [$clog2(LOG2N):0]     stage
);

  localparam int AW  = LOG2N;
  localparam int TWW = LOG2N - 1;
  localparam int KW  = LOG2N - 1;
  localparam int SW  = $clog2(LOG2N) + 1;
  localparam int DW  = $clog2(PIPE_LAT + 1);

  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        dcnt_d = dcnt_q + DW'(1);
        // Next stage may only read once every write of this stage has landed.
        if (dcnt_q == D_LAST) begin
          if (stage_q == S_LAST) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign busy  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done  = (state_q == ST_FIN);
  assign rd_en = (state_q == ST_RUN);
  assign stage = stage_q;

  // Addresses are forced to 0 outside RUN so the write-back pipe carries clean zeros.
  assign rd_addr_a = rd_en ? AW'(bfly_addr_a(32'(k_q), 32'(stage_q))) : '0;
  assign rd_addr_b = rd_en ? AW'(bfly_addr_a(32'(k_q), 32'(stage_q)) + bfly_span(32'(stage_q))) : '0;
  assign tw_addr   = rd_en ? TWW'(bfly_tw(32'(k_q), 32'(stage_q), LOG2N)) : '0;

  fft_wb_pipe #(
    .PIPE_LAT (PIPE_LAT),
    .AW       (AW)
  ) u_wb_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_i    (rd_en),
    .addr_a_i (rd_addr_a),
    .addr_b_i (rd_addr_b),
    .vld_o    (wr_en),
    .addr_a_o (wr_addr_a),
    .addr_b_o (wr_addr_b)
  );

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched with N=8, PIPE_LAT=3: schedule, addressing, write-back and an 8-point FFT model.
module tb_fft_bfly_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic [2:0] stage;

  fft_bfly_sched #(.LOG2N(3), .PIPE_LAT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int s; int k; int a; int b; int tw; } vec_t;
  typedef struct { int cyc; int a; int b; } wr_t;
  typedef struct { int z1r; int z1i; int z2r; int z2i; } bf_t;

  vec_t tab [12];
  wr_t  sbq [$];
  bf_t  bq  [$];
  int   mr [8];
  int   mi [8];
  int   twr [4];
  int   twi [4];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
    n_chk++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/-%0d", nm, act, exp, tol);
    end
  endtask

  function automatic int xin(input int pat, input int n);
    if (pat == 1) return (n == 0) ? 1000 : 0;
    return 1000;
  endfunction

  task automatic load_mem(input int pat);
    for (int n = 0; n < 8; n++) begin
      int r;
      r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      mr[r] = xin(pat, n);
      mi[r] = 0;
    end
  endtask

  // Operands read at issue, results written at the DUT-reported write addresses.
  task automatic model_step();
    if (wr_en) begin
      if (bq.size() != 0) begin
        bf_t w;
        w = bq.pop_front();
        mr[wr_addr_a] = w.z1r; mi[wr_addr_a] = w.z1i;
        mr[wr_addr_b] = w.z2r; mi[wr_addr_b] = w.z2i;
      end
    end
    if (rd_en) begin
      int tr, ti, wrr, wii;
      bf_t z;
      wrr = twr[tw_addr]; wii = twi[tw_addr];
      tr = (wrr * mr[rd_addr_b] - wii * mi[rd_addr_b] + 8192) >>> 14;
      ti = (wrr * mi[rd_addr_b] + wii * mr[rd_addr_b] + 8192) >>> 14;
      z.z1r = mr[rd_addr_a] + tr; z.z1i = mi[rd_addr_a] + ti;
      z.z2r = mr[rd_addr_a] - tr; z.z2i = mi[rd_addr_a] - ti;
      bq.push_back(z);
    end
  endtask

  task automatic check_fft(input int pat);
    for (int k = 0; k < 8; k++) begin
      real xr, xi;
      xr = 0.0; xi = 0.0;
      for (int n = 0; n < 8; n++) begin
        xr = xr + xin(pat, n) * $cos(2.0 * 3.14159265358979 * n * k / 8.0);
        xi = xi - xin(pat, n) * $sin(2.0 * 3.14159265358979 * n * k / 8.0);
      end
      chk_tol($sformatf("fft_re[%0d]", k), mr[k], $rtoi(xr + ((xr >= 0.0) ? 0.5 : -0.5)), 2);
      chk_tol($sformatf("fft_im[%0d]", k), mi[k], $rtoi(xi + ((xi >= 0.0) ? 0.5 : -0.5)), 2);
    end
  endtask

  // Call at a negedge with the DUT idle; start is driven in that cycle (rel 0).
  task automatic run_check(input bit extra, input int pat);
    int t0, ndone, nwr;
    t0 = cyc; ndone = 0; nwr = 0;
    if (pat != 0) load_mem(pat);
    sbq.delete();
    bq.delete();
    for (int i = 0; i < 12; i++) begin
      wr_t e;
      e.cyc = t0 + 1 + tab[i].s * 7 + tab[i].k + 3;
      e.a = tab[i].a; e.b = tab[i].b;
      sbq.push_back(e);
    end
    for (int rel = 0; rel <= 22; rel++) begin
      bit er;
      er = (rel >= 1) && (rel <= 21) && (((rel - 1) % 7) < 4);
      chk("rd_en", int'(rd_en), int'(er));
      chk("busy", int'(busy), int'((rel >= 1) && (rel <= 21)));
      chk("done", int'(done), int'(rel == 22));
      if (done) ndone++;
      if (er && rd_en) begin
        int idx;
        idx = ((rel - 1) / 7) * 4 + ((rel - 1) % 7);
        chk("rd_addr_a", int'(rd_addr_a), tab[idx].a);
        chk("rd_addr_b", int'(rd_addr_b), tab[idx].b);
        chk("tw_addr", int'(tw_addr), tab[idx].tw);
        chk("stage", int'(stage), tab[idx].s);
      end
      if (wr_en) begin
        nwr++;
        if (sbq.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          wr_t e;
          e = sbq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr_a", int'(wr_addr_a), e.a);
          chk("wr_addr_b", int'(wr_addr_b), e.b);
        end
      end
      if (pat != 0) model_step();
      start = (rel == 0) || (extra && ((rel == 5) || (rel == 22)));
      @(negedge clk);
    end
    chk("write_count", nwr, 12);
    chk("done_count", ndone, 1);
    chk("sb_left", sbq.size(), 0);
    if (pat != 0) check_fft(pat);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_rd_addr_a"}, int'(rd_addr_a), 0);
    chk({tag, "_rd_addr_b"}, int'(rd_addr_b), 0);
    chk({tag, "_tw_addr"}, int'(tw_addr), 0);
    chk({tag, "_wr_addr_a"}, int'(wr_addr_a), 0);
    chk({tag, "_wr_addr_b"}, int'(wr_addr_b), 0);
    chk({tag, "_stage"}, int'(stage), 0);
  endtask

  initial begin
    tab[0]  = '{0, 0, 0, 1, 0};
    tab[1]  = '{0, 1, 2, 3, 0};
    tab[2]  = '{0, 2, 4, 5, 0};
    tab[3]  = '{0, 3, 6, 7, 0};
    tab[4]  = '{1, 0, 0, 2, 0};
    tab[5]  = '{1, 1, 1, 3, 2};
    tab[6]  = '{1, 2, 4, 6, 0};
    tab[7]  = '{1, 3, 5, 7, 2};
    tab[8]  = '{2, 0, 0, 4, 0};
    tab[9]  = '{2, 1, 1, 5, 1};
    tab[10] = '{2, 2, 2, 6, 2};
    tab[11] = '{2, 3, 3, 7, 3};
    twr[0] = 16384;  twi[0] = 0;
    twr[1] = 11585;  twi[1] = -11585;
    twr[2] = 0;      twi[2] = -16384;
    twr[3] = -11585; twi[3] = -11585;

    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain run with impulse data.
    run_check(1'b0, 1);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Starts during busy and during FIN are dropped; the following cycle's start is taken.
    run_check(1'b1, 2);
    run_check(1'b0, 1);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of stage 1.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_reset_rd_en", int'(rd_en), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    bq.delete();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_reset_wr_en", int'(wr_en), 0);
      chk("post_reset_rd_en", int'(rd_en), 0);
      chk("post_reset_busy", int'(busy), 0);
    end
    run_check(1'b0, 2);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
